// File: rtl/vision_pkg.sv
// vision_pkg: shared pixel, mode and register-map definitions for the colour bbox stage.
package vision_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_MASK = 2'd1,
    MODE_BBOX = 2'd2
  } mode_e;
  localparam logic [1:0] REG_CFG = 2'd0;
  localparam logic [1:0] REG_MIN = 2'd1;
  localparam logic [1:0] REG_MAX = 2'd2;
  localparam logic [1:0] REG_CNT = 2'd3;
  localparam logic [3:0] HDR_VIDEO = 4'h0;
  // Differences are taken at 9 bits so a full-scale 0..255 gap never wraps.
  function automatic logic within_tol(input logic [7:0] a, input logic [7:0] b, input logic [7:0] tol);
    logic [8:0] d;
    d = (a >= b) ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
    return d <= {1'b0, tol};
  endfunction
endpackage

// File: rtl/colour_tracker.sv
// colour_tracker: one target colour -- cfg, match comparator, per-frame accumulators and latched box.
module colour_tracker import vision_pkg::*; #(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480,
  parameter int COORD_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_we,
  input  logic [31:0]           cfg_wdata,
  input  logic                  load,
  input  logic                  pix_valid,
  input  logic                  frame_end,
  input  rgb_t                  pix,
  input  logic [COORD_W-1:0]    x,
  input  logic [COORD_W-1:0]    y,
  output logic                  match,
  output logic                  on_perimeter,
  output rgb_t                  target,
  output logic [3:0][31:0]      regs
);
  localparam int CNT_W = $clog2(IMAGE_W * IMAGE_H + 1);
  // Packed as {ymax, xmax, ymin, xmin}: empty means min all ones, max zero.
  localparam logic [4*COORD_W-1:0] EMPTY = {{(2*COORD_W){1'b0}}, {(2*COORD_W){1'b1}}};
  logic [31:0] cfg_q, cfg_d, act_q, act_d;
  logic [3:0][COORD_W-1:0] acc_q, acc_d, acc_n, lat_q, lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n, lcnt_q, lcnt_d;
  assign target = act_q[23:0];
  assign match = within_tol(pix.r, target.r, act_q[31:24]) &
                 within_tol(pix.g, target.g, act_q[31:24]) &
                 within_tol(pix.b, target.b, act_q[31:24]);
  assign on_perimeter = (lcnt_q != '0) && x >= lat_q[0] && x <= lat_q[2] && y >= lat_q[1] && y <= lat_q[3] &&
                        (x == lat_q[0] || x == lat_q[2] || y == lat_q[1] || y == lat_q[3]);
  assign regs[REG_CFG] = cfg_q;
  assign regs[REG_MIN] = 32'({lat_q[1], lat_q[0]});
  assign regs[REG_MAX] = 32'({lat_q[3], lat_q[2]});
  assign regs[REG_CNT] = 32'(lcnt_q);
  always_comb begin
    acc_n = acc_q;
    cnt_n = cnt_q;
    if (pix_valid && match) begin
      acc_n[0] = (x < acc_q[0]) ? x : acc_q[0];
      acc_n[1] = (y < acc_q[1]) ? y : acc_q[1];
      acc_n[2] = (x > acc_q[2]) ? x : acc_q[2];
      acc_n[3] = (y > acc_q[3]) ? y : acc_q[3];
      cnt_n = &cnt_q ? cnt_q : cnt_q + 1'b1;
    end
    cfg_d = cfg_we ? cfg_wdata : cfg_q;
    act_d = load ? cfg_q : act_q;
    acc_d = frame_end ? EMPTY : acc_n;
    cnt_d = frame_end ? '0 : cnt_n;
    lat_d = frame_end ? acc_n : lat_q;
    lcnt_d = frame_end ? cnt_n : lcnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cfg_q <= '0;
      act_q <= '0;
      acc_q <= EMPTY;
      cnt_q <= '0;
      lat_q <= EMPTY;
      lcnt_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      act_q <= act_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
      lcnt_q <= lcnt_d;
    end
  end
endmodule

// File: rtl/video_colour_bbox.sv
// video_colour_bbox: inline Avalon-ST colour tracker with mask/bbox overlay and Avalon-MM results.
module video_colour_bbox import vision_pkg::*; #(
  parameter int IMAGE_W   = 640,
  parameter int IMAGE_H   = 480,
  parameter int N_COLOURS = 4,
  parameter int COORD_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mode,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_startofpacket,
  input  logic        sink_endofpacket,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_startofpacket,
  output logic        source_endofpacket,
  input  logic [4:0]  s_address,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  output logic [31:0] s_readdata
);
  logic src_valid_q, src_valid_d, sop_q, sop_d, eop_q, eop_d, video_q, video_d;
  logic [23:0] data_q, data_d;
  rgb_t out_px, mask_px, box_px;
  mode_e mode_q, mode_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [31:0] rd_q, rd_d;
  logic xfer, hdr, vid_hdr, pix, trk, frame_end, last_x;
  logic [N_COLOURS-1:0] match, perim;
  rgb_t tgt [N_COLOURS];
  logic [3:0][31:0] regs [N_COLOURS];
  assign sink_ready = source_ready | ~src_valid_q;
  assign xfer = sink_valid & sink_ready;
  assign hdr = xfer & sink_startofpacket;
  assign vid_hdr = hdr && sink_data[3:0] == HDR_VIDEO;
  assign pix = xfer & ~sink_startofpacket & video_q;
  assign trk = pix && y_q < COORD_W'(IMAGE_H);
  assign frame_end = xfer & sink_endofpacket & (sink_startofpacket ? vid_hdr : video_q);
  assign last_x = x_q == COORD_W'(IMAGE_W - 1);
  assign source_data = data_q;
  assign source_valid = src_valid_q;
  assign source_startofpacket = sop_q;
  assign source_endofpacket = eop_q;
  assign s_readdata = rd_q;
  for (genvar c = 0; c < N_COLOURS; c++) begin : g_trk
    colour_tracker #(.IMAGE_W(IMAGE_W), .IMAGE_H(IMAGE_H), .COORD_W(COORD_W)) u_trk (
      .clk(clk), .reset_n(reset_n),
      .cfg_we(s_write && s_address[4:2] == 3'(c) && s_address[1:0] == REG_CFG),
      .cfg_wdata(s_writedata), .load(vid_hdr), .pix_valid(trk), .frame_end(frame_end),
      .pix(sink_data), .x(x_q), .y(y_q),
      .match(match[c]), .on_perimeter(perim[c]), .target(tgt[c]), .regs(regs[c])
    );
  end
  always_comb begin
    mask_px = '0;
    box_px = sink_data;
    for (int i = N_COLOURS - 1; i >= 0; i--) begin
      mask_px = match[i] ? tgt[i] : mask_px;
      box_px = perim[i] ? tgt[i] : box_px;
    end
    // Headers, control packets and out-of-frame pixels always pass untouched.
    out_px = !trk ? sink_data : mode_q == MODE_MASK ? mask_px : mode_q == MODE_BBOX ? box_px : sink_data;
    src_valid_d = sink_ready ? sink_valid : src_valid_q;
    data_d = xfer ? out_px : data_q;
    sop_d = xfer ? sink_startofpacket : sop_q;
    eop_d = xfer ? sink_endofpacket : eop_q;
    video_d = hdr ? vid_hdr & ~sink_endofpacket : (xfer && sink_endofpacket) ? 1'b0 : video_q;
    mode_d = vid_hdr ? (mode == 2'd3 ? MODE_PASS : mode_e'(mode)) : mode_q;
    x_d = (vid_hdr || (pix && (sink_endofpacket || last_x))) ? '0 : pix ? x_q + 1'b1 : x_q;
    y_d = (vid_hdr || (pix && sink_endofpacket)) ? '0 :
          (pix && last_x && y_q < COORD_W'(IMAGE_H)) ? y_q + 1'b1 : y_q;
    rd_d = s_read ? '0 : rd_q;
    for (int i = 0; i < N_COLOURS; i++)
      rd_d = (s_read && s_address[4:2] == 3'(i)) ? regs[i][s_address[1:0]] : rd_d;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_valid_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      data_q <= '0;
      video_q <= 1'b0;
      mode_q <= MODE_PASS;
      x_q <= '0;
      y_q <= '0;
      rd_q <= '0;
    end else begin
      src_valid_q <= src_valid_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      data_q <= data_d;
      video_q <= video_d;
      mode_q <= mode_d;
      x_q <= x_d;
      y_q <= y_d;
      rd_q <= rd_d;
    end
  end
endmodule
